// File: rtl/filter_sync_mc.sv
// filter_sync_mc: per-channel in-flight transaction counters plus an
// active-low reconfiguration handshake. The acknowledge is granted only
// when every channel is drained. An optional timeout gives up if the
// channels do not drain in time.
module filter_sync_mc #(
  parameter int NCH      = 2,
  parameter int CW       = 16,
  parameter int INVALUE  = 1,
  parameter int OUTVALUE = 1,
  parameter int TIMEOUT  = 0,
  parameter int BLOCK_EN = 1
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] is_data_in,
  input  logic [NCH-1:0] is_data_out,
  input  logic           rc_reqn,
  output logic           rc_ackn,
  output logic           rc_block,
  output logic           rc_timeout,
  output logic [NCH-1:0] cnt_err
);

  localparam int              WW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0]   WLAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW+1:0]   CMAX  = {2'b00, {CW{1'b1}}};
  localparam logic [CW+1:0]   INC   = (CW+2)'(INVALUE);
  localparam logic [CW+1:0]   DEC   = (CW+2)'(OUTVALUE);

  typedef enum logic [1:0] {
    RC_Idle = 2'd0,
    RC_Req  = 2'd1,
    RC_Hold = 2'd2,
    RC_Tout = 2'd3
  } rc_state_t;

  rc_state_t      state, state_nxt;
  logic [WW-1:0]  wcnt, wcnt_nxt;
  logic [CW-1:0]  tc0    [NCH];
  logic [CW-1:0]  tc_nxt [NCH];
  logic [NCH-1:0] err_q, err_set;
  logic [CW+1:0]  up, dn;
  logic           all_idle;
  logic           ack_n, blk, tout;

  // Saturating next count per channel, error detection and the idle test
  // on the effective count (registered count plus this cycle's in-beat).
  always_comb begin
    tc_nxt   = tc0;
    err_set  = '0;
    all_idle = 1'b1;
    up       = '0;
    dn       = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      up = {2'b00, tc0[i]} + (is_data_in[i] ? INC : '0);
      if (up != '0) all_idle = 1'b0;
      if (is_data_out[i] && (up < DEC)) begin
        tc_nxt[i]  = '0;
        err_set[i] = 1'b1;
      end else begin
        dn = up - (is_data_out[i] ? DEC : '0);
        if (dn > CMAX) begin
          tc_nxt[i]  = '1;
          err_set[i] = 1'b1;
        end else begin
          tc_nxt[i] = dn[CW-1:0];
        end
      end
    end
  end

  // Counter and sticky error registers; they run in every FSM state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NCH; i++) tc0[i] <= '0;
      err_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH; i++) tc0[i] <= tc_nxt[i];
      err_q <= err_q | err_set;
    end
  end

  // Handshake state and wait-counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= RC_Idle;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Next-state and outputs. A released request in RC_Req wins over a
  // same-cycle drain so no acknowledge is shown for a withdrawn request.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = '0;
    ack_n     = 1'b1;
    blk       = 1'b0;
    tout      = 1'b0;
    case (state)
      RC_Idle: begin
        if (!rc_reqn) state_nxt = RC_Req;
      end
      RC_Req: begin
        blk = 1'b1;
        if (rc_reqn) begin
          state_nxt = RC_Idle;
        end else if (all_idle) begin
          ack_n     = 1'b0;
          state_nxt = RC_Hold;
        end else if ((TIMEOUT > 0) && (wcnt == WLAST)) begin
          state_nxt = RC_Tout;
        end else begin
          wcnt_nxt = wcnt + 1'b1;
        end
      end
      RC_Hold: begin
        blk   = 1'b1;
        ack_n = 1'b0;
        if (rc_reqn) state_nxt = RC_Idle;
      end
      RC_Tout: begin
        blk  = 1'b1;
        tout = 1'b1;
        if (rc_reqn) state_nxt = RC_Idle;
      end
      default: state_nxt = RC_Idle;
    endcase
  end

  assign rc_ackn    = ack_n;
  assign rc_block   = (BLOCK_EN == 1) ? blk : 1'b0;
  assign rc_timeout = tout;
  assign cnt_err    = err_q;

endmodule
